pic_priority_resolver_n: RTL and testbench
==========================================

PIC_PRIORITY_RESOLVER_N -- requirements
Module: pic_priority_resolver_n

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of request lines, legal range 2..32.
REQ-002 SHALL have parameter LTIM, default 0, trigger mode: 0 = edge, 1 = level.
REQ-003 SHALL derive local parameter W = clog2(N_IRQ), the level-number width.
REQ-004 SHALL provide ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ir  in  N_IRQ  raw interrupt request lines.
- imr  in  N_IRQ  mask; 1 = masked.
- eoi  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  qualifies eoi: 1 = specific, 0 = non-specific.
- eoi_level  in  W  target level for a specific EOI.
- aeoi  in  1  auto-EOI mode enable.
- rot_mode  in  1  automatic-rotation enable.
- vec_base  in  8  vector base; bits [7:W] used.
- inta_n  in  1  active-low acknowledge, synchronous to clk.
- int_o  out  1  interrupt request to CPU.
- vector  out  8  acknowledged vector.
- vector_valid  out  1  one-cycle vector qualifier.
- irr_o  out  N_IRQ  IRR contents.
- isr_o  out  N_IRQ  ISR contents.

Function
REQ-005 SHALL hold registered state: IRR[N_IRQ], ISR[N_IRQ], lowest-priority pointer lp[W], latched winner win[W], inta_n delay flop, and FSM {IDLE, ACK1}.
REQ-006 SHALL define priority as cyclic from lp: level (lp+1) mod N_IRQ is highest and lp is lowest; at lp = N_IRQ-1, IR0 is highest.
REQ-007 SHALL, when LTIM=0, set an IRR bit on a 0->1 edge of ir and clear it when ir is low or on acknowledge; if a new edge coincides with an acknowledge clear of the same bit, the bit SHALL remain set.
REQ-008 SHALL, when LTIM=1, load IRR from ir every cycle except the acknowledged bit, which is cleared in the ACK1-entry cycle.
REQ-009 SHALL define "eligible" as (IRR & ~imr) restricted to levels of strictly higher priority than the highest-priority set ISR bit (fully nested); all levels are eligible when ISR = 0.
REQ-010 SHALL drive int_o combinationally high whenever any eligible request exists.
REQ-011 SHALL treat an INTA strobe as a falling edge of inta_n, i.e. delayed inta_n = 1 and current inta_n = 0.
REQ-012 SHALL, on an INTA in IDLE:
- if an eligible request exists: latch the highest-priority eligible level into win, set ISR[win], clear IRR[win], and go to ACK1;
- if none exists: latch win = N_IRQ-1 as spurious, leave ISR and IRR unchanged, and go to ACK1.
REQ-013 SHALL, on an INTA in ACK1:
- drive vector = {vec_base[7:W], win} and vector_valid = 1 for exactly one cycle, then go to IDLE;
- if aeoi = 1 and the acknowledge was not spurious, clear ISR[win] in the same cycle, and if rot_mode = 1 also set lp = win.
REQ-014 SHALL, on a non-specific EOI, clear the highest-priority set ISR bit; if rot_mode = 1 it SHALL also set lp to that level; with ISR = 0 there SHALL be no effect.
REQ-015 SHALL, on a specific EOI, clear ISR[eoi_level]; if rot_mode = 1 it SHALL also set lp = eoi_level; eoi_level >= N_IRQ SHALL be ignored.
REQ-016 SHALL accept EOI in any FSM state; if it coincides with an AEOI clear of the same bit, the bit SHALL be cleared once and lp updated once.
REQ-017 SHALL ignore imr changes and new requests for the latched win while in ACK1, so win is stable.
REQ-018 SHALL hold vector at its last value whenever vector_valid = 0.
REQ-019 SHALL drive irr_o and isr_o directly from the registers.

Reset
REQ-020 SHALL, with rst_n low, asynchronously set IRR = 0, ISR = 0, lp = N_IRQ-1, win = 0, FSM = IDLE, delayed inta_n = 1, vector = 0 and vector_valid = 0, so int_o = 0.
REQ-021 SHALL, when reset is asserted mid-acknowledge, abandon the cycle and produce no vector_valid after reset release until two new INTA strobes occur.

Verification
REQ-022 SHALL cover: N_IRQ=8, LTIM=0, vec_base=8'h40, pulse ir[3] and ir[5], two INTA -> vector=8'h43, ISR=8'h08, IRR=8'h20, int_o=0 until a non-specific EOI, then int_o=1.
REQ-023 SHALL cover: rot_mode=1, IR2 serviced, then non-specific EOI -> lp=2, and with ir[1] and ir[3] pending the next vector is level 3.
REQ-024 SHALL cover: aeoi=1, IR0 acknowledged -> ISR=0 on the second-INTA cycle, vector_valid high for exactly 1 cycle.
REQ-025 SHALL cover: no eligible request (imr=8'hFF), two INTA -> vector={vec_base[7:3],3'd7}, ISR and IRR unchanged.
REQ-026 SHALL cover: N_IRQ=32, ir[31] and ir[0] set, specific EOI eoi_level=31 while ISR[31] set -> ISR[31] clears; eoi_level out of range ignored.
REQ-027 SHALL cover: rst_n low between the two INTA strobes -> all outputs at reset values, and no vector_valid on the next single INTA.

Source files
------------

// File: rtl/pic_priority_resolver_n.sv
// pic_priority_resolver_n
//
// Priority resolver for a programmable interrupt controller. It latches requests into
// IRR, tracks in-service levels in ISR, and resolves the highest-priority eligible
// request with fully nested priority. Priority is cyclic from the lowest-priority
// pointer lp. A two-strobe INTA handshake returns the vector. Both specific and
// non-specific EOI are supported, as are auto-EOI and automatic rotation.
//
// Parameters:
//   N_IRQ  number of request lines (2..32)
//   LTIM   trigger mode: 0 = edge, 1 = level
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   ir             raw interrupt request lines
//   imr            request mask, 1 = masked
//   eoi            one-cycle EOI strobe
//   eoi_specific   1 = specific EOI on eoi_level, 0 = non-specific
//   eoi_level      target level of a specific EOI
//   aeoi           auto-EOI enable
//   rot_mode       automatic-rotation enable
//   vec_base       vector base, bits [7:W] form the upper vector bits
//   inta_n         active-low acknowledge, synchronous to clk
//   int_o          interrupt request to the CPU
//   vector         acknowledged vector, held while vector_valid is low
//   vector_valid   one-cycle qualifier for vector
//   irr_o, isr_o   IRR and ISR register contents
module pic_priority_resolver_n #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned LTIM  = 0,
    localparam int unsigned W    = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] ir,
    input  logic [N_IRQ-1:0] imr,
    input  logic             eoi,
    input  logic             eoi_specific,
    input  logic [W-1:0]     eoi_level,
    input  logic             aeoi,
    input  logic             rot_mode,
    input  logic [7:0]       vec_base,
    input  logic             inta_n,
    output logic             int_o,
    output logic [7:0]       vector,
    output logic             vector_valid,
    output logic [N_IRQ-1:0] irr_o,
    output logic [N_IRQ-1:0] isr_o
);

    typedef enum logic {StIdle, StAck1} state_e;

    localparam logic [N_IRQ-1:0] One     = N_IRQ'(1);
    localparam logic [W-1:0]     LastLvl = W'(N_IRQ - 1);

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] irr_q, irr_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [N_IRQ-1:0] ir_q;
    logic [W-1:0]     lp_q, lp_d;
    logic [W-1:0]     win_q, win_d;
    logic             spur_q, spur_d;
    logic             inta_n_q;
    logic [7:0]       vector_q, vector_d;
    logic             vector_valid_q, vector_valid_d;

    logic             inta_strobe;
    logic [N_IRQ-1:0] isr_set, isr_clr, ack_clr;

    // Priority scan results
    logic [W-1:0]     lvl;
    logic             blocked;
    logic             have_win;
    logic [W-1:0]     win_lvl;
    logic             isr_found;
    logic [W-1:0]     isr_top;

    // Low vector bits come from win, so these base bits are not used.
    logic unused_vec_base;
    assign unused_vec_base = ^vec_base[W-1:0];

    // Walk levels from highest to lowest priority. The first in-service level found
    // blocks every level below it, which gives fully nested behaviour.
    always_comb begin
        lvl       = '0;
        blocked   = 1'b0;
        have_win  = 1'b0;
        win_lvl   = '0;
        isr_found = 1'b0;
        isr_top   = '0;
        for (int k = 0; k < int'(N_IRQ); k++) begin
            lvl = W'((int'(lp_q) + 1 + k) % int'(N_IRQ));
            if (!blocked) begin
                if (isr_q[lvl]) begin
                    blocked   = 1'b1;
                    isr_found = 1'b1;
                    isr_top   = lvl;
                end else if (!have_win && irr_q[lvl] && !imr[lvl]) begin
                    have_win = 1'b1;
                    win_lvl  = lvl;
                end
            end
        end
    end

    assign inta_strobe = inta_n_q & ~inta_n;

    always_comb begin
        state_d        = state_q;
        win_d          = win_q;
        spur_d         = spur_q;
        lp_d           = lp_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        isr_set        = '0;
        isr_clr        = '0;
        ack_clr        = '0;

        unique case (state_q)
            StIdle: begin
                if (inta_strobe) begin
                    state_d = StAck1;
                    if (have_win) begin
                        win_d   = win_lvl;
                        spur_d  = 1'b0;
                        isr_set = One << win_lvl;
                        ack_clr = One << win_lvl;
                    end else begin
                        win_d  = LastLvl;
                        spur_d = 1'b1;
                    end
                end
            end
            StAck1: begin
                if (inta_strobe) begin
                    state_d        = StIdle;
                    vector_d       = {vec_base[7:W], win_q};
                    vector_valid_d = 1'b1;
                    if (aeoi && !spur_q) begin
                        isr_clr = isr_clr | (One << win_q);
                        if (rot_mode) begin
                            lp_d = win_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // EOI applies in any state. A coincident auto-EOI of the same level only
        // clears the same bit and writes the same lp value.
        if (eoi) begin
            if (eoi_specific) begin
                if (int'(eoi_level) < int'(N_IRQ)) begin
                    isr_clr = isr_clr | (One << eoi_level);
                    if (rot_mode) begin
                        lp_d = eoi_level;
                    end
                end
            end else if (isr_found) begin
                isr_clr = isr_clr | (One << isr_top);
                if (rot_mode) begin
                    lp_d = isr_top;
                end
            end
        end

        isr_d = (isr_q & ~isr_clr) | isr_set;

        if (LTIM != 0) begin
            irr_d = ir & ~ack_clr;
        end else begin
            // A fresh edge wins over the acknowledge clear of the same bit.
            irr_d = (irr_q & ir & ~ack_clr) | (ir & ~ir_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            irr_q          <= '0;
            isr_q          <= '0;
            ir_q           <= '0;
            lp_q           <= LastLvl;
            win_q          <= '0;
            spur_q         <= 1'b0;
            inta_n_q       <= 1'b1;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            irr_q          <= irr_d;
            isr_q          <= isr_d;
            ir_q           <= ir;
            lp_q           <= lp_d;
            win_q          <= win_d;
            spur_q         <= spur_d;
            inta_n_q       <= inta_n;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
        end
    end

    assign int_o        = have_win;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign irr_o        = irr_q;
    assign isr_o        = isr_q;

endmodule

// File: tb/tb_pic_priority_resolver_n.sv
// Directed bench for pic_priority_resolver_n. Three instances (8, 32 and 6 lines)
// share clock, reset, INTA, EOI strobe and mode inputs; each has its own request,
// mask and level inputs. Inputs change on the falling edge and outputs are sampled
// on the falling edge.
module tb_pic_priority_resolver_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n        = 1'b0;
    logic       eoi          = 1'b0;
    logic       eoi_specific = 1'b0;
    logic       aeoi         = 1'b0;
    logic       rot_mode     = 1'b0;
    logic [7:0] vec_base     = 8'h40;
    logic       inta_n       = 1'b1;

    logic [7:0]  ir8 = '0, imr8 = '0;
    logic [2:0]  el8 = '0;
    logic        int8, vv8;
    logic [7:0]  vec8, irr8, isr8;

    logic [31:0] ir32 = '0, imr32 = '0;
    logic [4:0]  el32 = '0;
    logic        int32, vv32;
    logic [7:0]  vec32;
    logic [31:0] irr32, isr32;

    logic [5:0]  ir6 = '0, imr6 = '0;
    logic [2:0]  el6 = '0;
    logic        int6, vv6;
    logic [7:0]  vec6;
    logic [5:0]  irr6, isr6;

    logic       cap_vv8, cap_vv32, cap_vv6;
    logic [7:0] cap_vec8, cap_vec32, cap_vec6;

    int checks = 0;
    int errors = 0;

    pic_priority_resolver_n #(.N_IRQ(8), .LTIM(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .ir(ir8), .imr(imr8), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(el8), .aeoi(aeoi), .rot_mode(rot_mode),
        .vec_base(vec_base), .inta_n(inta_n), .int_o(int8), .vector(vec8),
        .vector_valid(vv8), .irr_o(irr8), .isr_o(isr8)
    );

    pic_priority_resolver_n #(.N_IRQ(32), .LTIM(0)) dut32 (
        .clk(clk), .rst_n(rst_n), .ir(ir32), .imr(imr32), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(el32), .aeoi(aeoi), .rot_mode(rot_mode),
        .vec_base(vec_base), .inta_n(inta_n), .int_o(int32), .vector(vec32),
        .vector_valid(vv32), .irr_o(irr32), .isr_o(isr32)
    );

    pic_priority_resolver_n #(.N_IRQ(6), .LTIM(0)) dut6 (
        .clk(clk), .rst_n(rst_n), .ir(ir6), .imr(imr6), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(el6), .aeoi(aeoi), .rot_mode(rot_mode),
        .vec_base(vec_base), .inta_n(inta_n), .int_o(int6), .vector(vec6),
        .vector_valid(vv6), .irr_o(irr6), .isr_o(isr6)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One INTA strobe; captures the outputs of the cycle right after the strobe edge.
    task automatic inta();
        inta_n = 1'b0;
        @(negedge clk);
        cap_vv8  = vv8;  cap_vec8  = vec8;
        cap_vv32 = vv32; cap_vec32 = vec32;
        cap_vv6  = vv6;  cap_vec6  = vec6;
        inta_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic eoi_pulse(input logic spec);
        eoi_specific = spec;
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
        eoi_specific = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (irr8 !== 8'h00) begin errors++;
            $display("FAIL reset_irr: got %h expected 00", irr8); end
        checks++; if (isr8 !== 8'h00) begin errors++;
            $display("FAIL reset_isr: got %h expected 00", isr8); end
        checks++; if (int8 !== 1'b0) begin errors++;
            $display("FAIL reset_int: got %b expected 0", int8); end
        checks++; if (vec8 !== 8'h00 || vv8 !== 1'b0) begin errors++;
            $display("FAIL reset_vector: got %h/%b expected 00/0", vec8, vv8); end
        checks++; if (isr32 !== 32'h0 || int32 !== 1'b0) begin errors++;
            $display("FAIL reset_n32: got isr %h int %b expected 0/0", isr32, int32); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_nested();
        ir8 = 8'h28;
        tick(1);
        checks++; if (irr8 !== 8'h28 || int8 !== 1'b1) begin errors++;
            $display("FAIL nest_latch: got irr %h int %b expected 28/1", irr8, int8); end
        inta();
        checks++; if (isr8 !== 8'h08 || irr8 !== 8'h20) begin errors++;
            $display("FAIL nest_ack1: got isr %h irr %h expected 08/20", isr8, irr8); end
        inta();
        checks++; if (cap_vv8 !== 1'b1 || cap_vec8 !== 8'h43) begin errors++;
            $display("FAIL nest_vector: got %b/%h expected 1/43", cap_vv8, cap_vec8); end
        checks++; if (vv8 !== 1'b0 || vec8 !== 8'h43) begin errors++;
            $display("FAIL nest_hold: got %b/%h expected 0/43", vv8, vec8); end
        checks++; if (int8 !== 1'b0 || isr8 !== 8'h08 || irr8 !== 8'h20) begin errors++;
            $display("FAIL nest_block: got int %b isr %h irr %h expected 0/08/20",
                     int8, isr8, irr8); end
        eoi_pulse(1'b0);
        checks++; if (isr8 !== 8'h00 || int8 !== 1'b1) begin errors++;
            $display("FAIL nest_eoi: got isr %h int %b expected 00/1", isr8, int8); end
        ir8 = 8'h00;
        tick(1);
        checks++; if (irr8 !== 8'h00) begin errors++;
            $display("FAIL nest_edge_drop: got %h expected 00", irr8); end
    endtask

    task automatic test_rotation();
        rot_mode = 1'b1;
        ir8 = 8'h04;
        tick(1);
        inta(); inta();
        checks++; if (cap_vec8 !== 8'h42 || isr8 !== 8'h04) begin errors++;
            $display("FAIL rot_first: got vec %h isr %h expected 42/04", cap_vec8, isr8); end
        ir8 = 8'h0E;
        tick(1);
        checks++; if (irr8 !== 8'h0A || int8 !== 1'b1) begin errors++;
            $display("FAIL rot_pending: got irr %h int %b expected 0A/1", irr8, int8); end
        eoi_pulse(1'b0);
        checks++; if (isr8 !== 8'h00) begin errors++;
            $display("FAIL rot_eoi: got %h expected 00", isr8); end
        inta(); inta();
        checks++; if (cap_vec8 !== 8'h43 || isr8 !== 8'h08 || irr8 !== 8'h02) begin errors++;
            $display("FAIL rot_next: got vec %h isr %h irr %h expected 43/08/02",
                     cap_vec8, isr8, irr8); end
        eoi_pulse(1'b0);
        rot_mode = 1'b0;
        ir8 = 8'h00;
        tick(1);
        checks++; if (isr8 !== 8'h00 || irr8 !== 8'h00) begin errors++;
            $display("FAIL rot_clean: got isr %h irr %h expected 00/00", isr8, irr8); end
    endtask

    task automatic test_aeoi();
        aeoi = 1'b1;
        ir8 = 8'h01;
        tick(1);
        inta();
        checks++; if (isr8 !== 8'h01) begin errors++;
            $display("FAIL aeoi_ack1: got %h expected 01", isr8); end
        inta_n = 1'b0;
        @(negedge clk);
        checks++; if (vv8 !== 1'b1 || vec8 !== 8'h40 || isr8 !== 8'h00) begin errors++;
            $display("FAIL aeoi_ack2: got vv %b vec %h isr %h expected 1/40/00",
                     vv8, vec8, isr8); end
        inta_n = 1'b1;
        @(negedge clk);
        checks++; if (vv8 !== 1'b0) begin errors++;
            $display("FAIL aeoi_one_cycle: got %b expected 0", vv8); end
        aeoi = 1'b0;
        ir8 = 8'h00;
        tick(1);
    endtask

    task automatic test_spurious();
        imr8 = 8'hFF;
        ir8 = 8'h10;
        tick(1);
        checks++; if (int8 !== 1'b0 || irr8 !== 8'h10) begin errors++;
            $display("FAIL spur_masked: got int %b irr %h expected 0/10", int8, irr8); end
        inta(); inta();
        checks++; if (cap_vv8 !== 1'b1 || cap_vec8 !== 8'h47) begin errors++;
            $display("FAIL spur_vector: got %b/%h expected 1/47", cap_vv8, cap_vec8); end
        checks++; if (isr8 !== 8'h00 || irr8 !== 8'h10) begin errors++;
            $display("FAIL spur_regs: got isr %h irr %h expected 00/10", isr8, irr8); end
        imr8 = 8'h00;
        ir8 = 8'h00;
        tick(1);
    endtask

    task automatic test_n32();
        ir32 = 32'h8000_0001;
        imr32 = 32'h0000_0001;
        tick(1);
        checks++; if (irr32 !== 32'h8000_0001 || int32 !== 1'b1) begin errors++;
            $display("FAIL n32_latch: got irr %h int %b expected 80000001/1", irr32, int32); end
        inta(); inta();
        checks++; if (cap_vv32 !== 1'b1 || cap_vec32 !== 8'h5F) begin errors++;
            $display("FAIL n32_vector: got %b/%h expected 1/5f", cap_vv32, cap_vec32); end
        checks++; if (isr32 !== 32'h8000_0000 || irr32 !== 32'h1 || int32 !== 1'b0) begin
            errors++;
            $display("FAIL n32_regs: got isr %h irr %h int %b expected 80000000/1/0",
                     isr32, irr32, int32); end
        el32 = 5'd30;
        eoi_pulse(1'b1);
        checks++; if (isr32 !== 32'h8000_0000) begin errors++;
            $display("FAIL n32_eoi_other: got %h expected 80000000", isr32); end
        el32 = 5'd31;
        eoi_pulse(1'b1);
        checks++; if (isr32 !== 32'h0) begin errors++;
            $display("FAIL n32_eoi_31: got %h expected 0", isr32); end
        ir32 = '0;
        imr32 = '0;
        tick(1);
    endtask

    task automatic test_eoi_range();
        ir6 = 6'h20;
        tick(1);
        inta(); inta();
        checks++; if (cap_vv6 !== 1'b1 || cap_vec6 !== 8'h45) begin errors++;
            $display("FAIL n6_vector: got %b/%h expected 1/45", cap_vv6, cap_vec6); end
        checks++; if (isr6 !== 6'h20 || irr6 !== 6'h00 || int6 !== 1'b0) begin errors++;
            $display("FAIL n6_regs: got isr %h irr %h int %b expected 20/00/0",
                     isr6, irr6, int6); end
        el6 = 3'd7;
        eoi_pulse(1'b1);
        checks++; if (isr6 !== 6'h20) begin errors++;
            $display("FAIL n6_eoi_7: got %h expected 20", isr6); end
        el6 = 3'd6;
        eoi_pulse(1'b1);
        checks++; if (isr6 !== 6'h20) begin errors++;
            $display("FAIL n6_eoi_6: got %h expected 20", isr6); end
        el6 = 3'd5;
        eoi_pulse(1'b1);
        checks++; if (isr6 !== 6'h00) begin errors++;
            $display("FAIL n6_eoi_5: got %h expected 00", isr6); end
        ir6 = '0;
        tick(1);
    endtask

    task automatic test_reset_mid_ack();
        ir8 = 8'h02;
        tick(1);
        inta();
        checks++; if (isr8 !== 8'h02) begin errors++;
            $display("FAIL mid_ack1: got %h expected 02", isr8); end
        rst_n = 1'b0;
        #1;
        checks++; if (irr8 !== 8'h00 || isr8 !== 8'h00 || int8 !== 1'b0) begin errors++;
            $display("FAIL mid_reset_regs: got irr %h isr %h int %b expected 00/00/0",
                     irr8, isr8, int8); end
        checks++; if (vec8 !== 8'h00 || vv8 !== 1'b0) begin errors++;
            $display("FAIL mid_reset_vec: got %h/%b expected 00/0", vec8, vv8); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        checks++; if (irr8 !== 8'h02) begin errors++;
            $display("FAIL mid_relatch: got %h expected 02", irr8); end
        inta();
        checks++; if (cap_vv8 !== 1'b0 || vv8 !== 1'b0) begin errors++;
            $display("FAIL mid_no_valid: got %b/%b expected 0/0", cap_vv8, vv8); end
        checks++; if (isr8 !== 8'h02) begin errors++;
            $display("FAIL mid_reack: got %h expected 02", isr8); end
    endtask

    initial begin
        test_reset();
        test_nested();
        test_rotation();
        test_aeoi();
        test_spurious();
        test_n32();
        test_eoi_range();
        test_reset_mid_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
